// File: rtl/rfs_frame_writer.sv
// rfs_frame_writer: packs a sensor byte stream into little-endian 32-bit words
// and writes one frame into an on-chip memory, one word per cycle at most.
// Frames are armed by a start pulse and begin at the first s_sop byte.
module rfs_frame_writer #(
    parameter int DEPTH  = 37500,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_sop,
    input  logic              s_eop,
    output logic              s_ready,
    output logic [ADDR_W-1:0] m_address,
    output logic [3:0]        m_byteenable,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    output logic              m_clken,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] word_count,
    output logic              overflow,
    output logic              resync
);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FLUSH} state_t;

    // One extra bit so the limit compare also works when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        lane;
    logic [7:0]        buf0, buf1, buf2;

    logic              take, first, room, wr_full, wr_part, drop, fd_nxt, arm;
    logic [1:0]        cur_lane;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       word_asm;
    logic [3:0]        be_part;

    // Port-level controls derived straight from the state register.
    assign s_ready    = (state == ARMED) || (state == CAPTURE);
    assign busy       = (state != IDLE);
    assign m_clken    = 1'b1;
    assign word_count = addr;

    // Byte acceptance, word assembly and next-state decode.
    always_comb begin
        state_nxt = state;
        arm       = (state == IDLE) && start;
        // Bytes in ARMED are only taken into the frame once s_sop arrives.
        take      = s_valid && s_ready && ((state == CAPTURE) || s_sop);
        first     = take && s_sop;
        // A fresh s_sop restarts the frame: lane 0 at address 0.
        cur_lane  = first ? 2'd0 : lane;
        cur_addr  = first ? '0 : addr;
        room      = {1'b0, cur_addr} < DEPTH_L;
        wr_full   = take && room && (cur_lane == 2'd3);
        wr_part   = take && room && s_eop && (cur_lane != 2'd3);
        drop      = take && !room;
        // Partial frames get frame_done one cycle after their flush write.
        fd_nxt    = (state == FLUSH) || (take && s_eop && !wr_part);

        word_asm[7:0]   = (cur_lane == 2'd0) ? s_data : buf0;
        word_asm[15:8]  = (cur_lane == 2'd1) ? s_data : (cur_lane > 2'd1) ? buf1 : 8'h00;
        word_asm[23:16] = (cur_lane == 2'd2) ? s_data : (cur_lane == 2'd3) ? buf2 : 8'h00;
        word_asm[31:24] = (cur_lane == 2'd3) ? s_data : 8'h00;

        case (cur_lane)
            2'd0:    be_part = 4'b0001;
            2'd1:    be_part = 4'b0011;
            default: be_part = 4'b0111;
        endcase

        case (state)
            IDLE:    if (arm) state_nxt = ARMED;
            ARMED,
            CAPTURE: begin
                if (take) begin
                    if (s_eop)
                        state_nxt = wr_part ? FLUSH : IDLE;
                    else
                        state_nxt = CAPTURE;
                end
            end
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Frame bookkeeping, sticky flags and the registered memory port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr         <= '0;
            lane         <= 2'd0;
            overflow     <= 1'b0;
            resync       <= 1'b0;
            frame_done   <= 1'b0;
            m_write      <= 1'b0;
            m_chipselect <= 1'b0;
            m_byteenable <= 4'h0;
            m_address    <= '0;
            m_writedata  <= 32'h0;
        end else begin
            frame_done   <= fd_nxt;
            m_write      <= wr_full || wr_part;
            m_chipselect <= wr_full || wr_part;
            m_byteenable <= wr_full ? 4'hF : (wr_part ? be_part : 4'h0);
            if (wr_full || wr_part) begin
                m_address   <= cur_addr;
                m_writedata <= word_asm;
            end
            if (arm) begin
                addr     <= '0;
                lane     <= 2'd0;
                overflow <= 1'b0;
                resync   <= 1'b0;
            end else if (take) begin
                lane <= cur_lane + 2'd1;
                addr <= cur_addr + {{(ADDR_W-1){1'b0}}, (wr_full || wr_part)};
                if (first && (state == CAPTURE)) resync   <= 1'b1;
                if (drop)                        overflow <= 1'b1;
            end
        end
    end

    // Holding bytes for lanes 0..2; lane 3 goes straight into the write.
    always_ff @(posedge clk) begin
        if (take) begin
            case (cur_lane)
                2'd0:    buf0 <= s_data;
                2'd1:    buf1 <= s_data;
                2'd2:    buf2 <= s_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rfs_frame_writer.sv
// tb_rfs_frame_writer: table-driven cycle vectors plus directed multi-cycle
// sequences and a randomized frame scoreboard for rfs_frame_writer (DEPTH=4).
module tb_rfs_frame_writer;

    localparam int DEPTH = 4;
    localparam int AW    = 16;

    logic          clk, reset_n, start, s_valid, s_sop, s_eop;
    logic [7:0]    s_data;
    logic          s_ready, m_chipselect, m_write, m_clken, busy, frame_done;
    logic          overflow, resync;
    logic [AW-1:0] m_address, word_count;
    logic [3:0]    m_byteenable;
    logic [31:0]   m_writedata;

    rfs_frame_writer #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .s_valid(s_valid), .s_data(s_data), .s_sop(s_sop), .s_eop(s_eop),
        .s_ready(s_ready), .m_address(m_address), .m_byteenable(m_byteenable),
        .m_chipselect(m_chipselect), .m_write(m_write), .m_writedata(m_writedata),
        .m_clken(m_clken), .busy(busy), .frame_done(frame_done),
        .word_count(word_count), .overflow(overflow), .resync(resync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bemask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Write monitor, sampled on the falling edge.
    typedef struct {
        logic [AW-1:0] a;
        logic [3:0]    be;
        logic [31:0]   d;
    } wr_t;
    wr_t wlog[$];
    int  fd_cnt = 0;
    int  bad_wr = 0;

    always @(negedge clk) begin
        if (m_write) wlog.push_back('{m_address, m_byteenable, m_writedata});
        if (frame_done) fd_cnt++;
        if ((m_write && (m_address >= DEPTH)) || (m_chipselect !== m_write)) bad_wr++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic v, input logic [7:0] d,
                         input logic sop, input logic eop);
        start = st; s_valid = v; s_data = d; s_sop = sop; s_eop = eop;
    endtask

    task automatic send(input logic [7:0] d, input logic sop, input logic eop);
        drive(1'b0, 1'b1, d, sop, eop);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic pulse_start();
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".s_ready"}, s_ready, 0);
        chk({tag, ".m_write"}, m_write, 0);
        chk({tag, ".m_cs"}, m_chipselect, 0);
        chk({tag, ".m_addr"}, m_address, 0);
        chk({tag, ".m_be"}, m_byteenable, 0);
        chk({tag, ".m_data"}, m_writedata, 0);
        chk({tag, ".m_clken"}, m_clken, 1);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".frame_done"}, frame_done, 0);
        chk({tag, ".word_count"}, word_count, 0);
        chk({tag, ".overflow"}, overflow, 0);
        chk({tag, ".resync"}, resync, 0);
    endtask

    // Cycle vectors: inputs applied before an edge, outputs expected after it.
    typedef struct {
        logic          st, v;
        logic [7:0]    d;
        logic          sop, eop;
        logic          rdy, bsy, wr;
        logic [AW-1:0] a;
        logic [3:0]    be;
        logic [31:0]   dat;
        logic          fd;
        logic [AW-1:0] wc;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic st, input logic v, input logic [7:0] d,
                                input logic sop, input logic eop,
                                input logic rdy, input logic bsy, input logic wr,
                                input logic [AW-1:0] a, input logic [3:0] be,
                                input logic [31:0] dat, input logic fd,
                                input logic [AW-1:0] wc);
        tbl.push_back('{st, v, d, sop, eop, rdy, bsy, wr, a, be, dat, fd, wc});
    endfunction

    initial begin
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk_reset_values("reset");
        #20 reset_n = 1'b1;
        step();

        // 8-byte frame; the start on byte 5 must be ignored.
        add(1,0,8'h00,0,0, 1,1,0, 0,4'h0,32'h0,        0,0);
        add(0,1,8'h01,1,0, 1,1,0, 0,4'h0,32'h0,        0,0);
        add(0,1,8'h02,0,0, 1,1,0, 0,4'h0,32'h0,        0,0);
        add(0,1,8'h03,0,0, 1,1,0, 0,4'h0,32'h0,        0,0);
        add(0,1,8'h04,0,0, 1,1,1, 0,4'hF,32'h04030201, 0,1);
        add(1,1,8'h05,0,0, 1,1,0, 0,4'h0,32'h0,        0,1);
        add(0,1,8'h06,0,0, 1,1,0, 0,4'h0,32'h0,        0,1);
        add(0,1,8'h07,0,0, 1,1,0, 0,4'h0,32'h0,        0,1);
        add(0,1,8'h08,0,1, 0,0,1, 1,4'hF,32'h08070605, 1,2);
        add(0,0,8'h00,0,0, 0,0,0, 0,4'h0,32'h0,        0,2);
        // 6-byte frame: full word, then a flushed 2-byte word.
        add(1,0,8'h00,0,0, 1,1,0, 0,4'h0,32'h0,        0,0);
        add(0,1,8'hA0,1,0, 1,1,0, 0,4'h0,32'h0,        0,0);
        add(0,1,8'hA1,0,0, 1,1,0, 0,4'h0,32'h0,        0,0);
        add(0,1,8'hA2,0,0, 1,1,0, 0,4'h0,32'h0,        0,0);
        add(0,1,8'hA3,0,0, 1,1,1, 0,4'hF,32'hA3A2A1A0, 0,1);
        add(0,1,8'hA4,0,0, 1,1,0, 0,4'h0,32'h0,        0,1);
        add(0,1,8'hA5,0,1, 0,1,1, 1,4'h3,32'h0000A5A4, 0,2);
        add(0,0,8'h00,0,0, 0,0,0, 0,4'h0,32'h0,        1,2);
        add(0,0,8'h00,0,0, 0,0,0, 0,4'h0,32'h0,        0,2);
        // Non-sop byte in ARMED is dropped; sop+eop byte is a one-byte frame.
        add(1,0,8'h00,0,0, 1,1,0, 0,4'h0,32'h0,        0,0);
        add(0,1,8'h77,0,0, 1,1,0, 0,4'h0,32'h0,        0,0);
        add(0,1,8'h5A,1,1, 0,1,1, 0,4'h1,32'h0000005A, 0,1);
        add(0,0,8'h00,0,0, 0,0,0, 0,4'h0,32'h0,        1,1);
        // Byte offered in IDLE is not accepted; word_count holds.
        add(0,1,8'h99,1,1, 0,0,0, 0,4'h0,32'h0,        0,1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].st, tbl[i].v, tbl[i].d, tbl[i].sop, tbl[i].eop);
            step();
            chk($sformatf("v%0d.s_ready", i), s_ready, tbl[i].rdy);
            chk($sformatf("v%0d.busy", i), busy, tbl[i].bsy);
            chk($sformatf("v%0d.m_write", i), m_write, tbl[i].wr);
            chk($sformatf("v%0d.m_cs", i), m_chipselect, tbl[i].wr);
            chk($sformatf("v%0d.frame_done", i), frame_done, tbl[i].fd);
            chk($sformatf("v%0d.word_count", i), word_count, tbl[i].wc);
            if (tbl[i].wr) begin
                chk($sformatf("v%0d.m_addr", i), m_address, tbl[i].a);
                chk($sformatf("v%0d.m_be", i), m_byteenable, tbl[i].be);
                chk($sformatf("v%0d.m_data", i), m_writedata & bemask(tbl[i].be), tbl[i].dat);
            end
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step();

        // Overflow: 20-byte frame into a 4-word memory.
        wlog.delete();
        fd_cnt = 0;
        pulse_start();
        for (int b = 1; b <= 20; b++) begin
            if (b > 16) chk($sformatf("ovf.s_ready_b%0d", b), s_ready, 1);
            send(8'(b), b == 1, b == 20);
            if (b < 20) chk($sformatf("ovf.no_done_b%0d", b), frame_done, 0);
        end
        chk("ovf.frame_done", frame_done, 1);
        chk("ovf.overflow", overflow, 1);
        chk("ovf.word_count", word_count, 4);
        chk("ovf.busy", busy, 0);
        step();
        chk("ovf.writes", wlog.size(), 4);
        chk("ovf.done_count", fd_cnt, 1);
        for (int k = 0; k < 4 && k < wlog.size(); k++) begin
            chk($sformatf("ovf.addr%0d", k), wlog[k].a, k);
            chk($sformatf("ovf.data%0d", k), wlog[k].d,
                {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)});
        end

        // Stray bytes before start and before sop, then a mid-frame sop.
        wlog.delete();
        fd_cnt = 0;
        send(8'h31, 1'b1, 1'b0);
        send(8'h32, 1'b1, 1'b1);
        pulse_start();
        send(8'h41, 1'b0, 1'b0);
        send(8'h42, 1'b0, 1'b1);
        chk("rs.armed_still", busy, 1);
        for (int b = 0; b < 5; b++) send(8'h10 + 8'(b), b == 0, 1'b0);
        chk("rs.resync_before", resync, 0);
        chk("rs.wc_before", word_count, 1);
        send(8'h20, 1'b1, 1'b0);
        chk("rs.resync_set", resync, 1);
        chk("rs.wc_cleared", word_count, 0);
        send(8'h21, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h23, 1'b0, 1'b1);
        chk("rs.frame_done", frame_done, 1);
        chk("rs.word_count", word_count, 1);
        step();
        chk("rs.writes", wlog.size(), 2);
        if (wlog.size() >= 2) begin
            chk("rs.addr0", wlog[0].a, 0);
            chk("rs.data0", wlog[0].d, 32'h13121110);
            chk("rs.addr1", wlog[1].a, 0);
            chk("rs.be1", wlog[1].be, 4'hF);
            chk("rs.data1", wlog[1].d, 32'h23222120);
        end
        chk("rs.resync_held", resync, 1);

        // Asynchronous reset in the middle of a frame.
        wlog.delete();
        fd_cnt = 0;
        pulse_start();
        send(8'h50, 1'b1, 1'b0);
        send(8'h51, 1'b0, 1'b0);
        send(8'h52, 1'b1, 1'b0);
        send(8'h53, 1'b0, 1'b0);
        chk("rst.resync_pre", resync, 1);
        reset_n = 1'b0;
        #1;
        chk_reset_values("rst");
        #3 reset_n = 1'b1;
        step();
        send(8'h54, 1'b1, 1'b0);
        chk("rst.not_armed", s_ready, 0);
        pulse_start();
        for (int b = 0; b < 4; b++) send(8'h60 + 8'(b), b == 0, b == 3);
        chk("rst.frame_done", frame_done, 1);
        step();
        chk("rst.writes", wlog.size(), 1);
        if (wlog.size() >= 1) begin
            chk("rst.addr0", wlog[0].a, 0);
            chk("rst.be0", wlog[0].be, 4'hF);
            chk("rst.data0", wlog[0].d, 32'h63626160);
        end

        // Random frames with random s_valid gaps against a byte-stream model.
        for (int f = 0; f < 1000; f++) begin
            int          len, nw, fd0, gaps;
            logic [7:0]  bytes[$];
            logic [3:0]  be;
            logic [31:0] exp_w;
            wlog.delete();
            bytes.delete();
            len = $urandom_range(1, 24);
            for (int b = 0; b < len; b++) bytes.push_back(8'($urandom_range(0, 255)));
            fd0 = fd_cnt;
            pulse_start();
            for (int b = 0; b < len; b++) begin
                gaps = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                for (int g = 0; g < gaps; g++) begin
                    drive(1'b0, 1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
                    step();
                end
                send(bytes[b], b == 0, b == len - 1);
            end
            for (int w = 0; w < 4 && fd_cnt == fd0; w++) step();
            chk($sformatf("rnd%0d.frame_done", f), fd_cnt, fd0 + 1);
            nw = (len + 3) / 4;
            if (nw > DEPTH) nw = DEPTH;
            chk($sformatf("rnd%0d.writes", f), wlog.size(), nw);
            chk($sformatf("rnd%0d.overflow", f), overflow, len > 4 * DEPTH);
            chk($sformatf("rnd%0d.word_count", f), word_count, nw);
            for (int k = 0; k < nw && k < wlog.size(); k++) begin
                exp_w = 32'h0;
                for (int n = 0; n < 4; n++) begin
                    be[n] = (4 * k + n) < len;
                    if (be[n]) exp_w[8*n +: 8] = bytes[4*k+n];
                end
                chk($sformatf("rnd%0d.addr%0d", f, k), wlog[k].a, k);
                chk($sformatf("rnd%0d.be%0d", f, k), wlog[k].be, be);
                chk($sformatf("rnd%0d.data%0d", f, k), wlog[k].d & bemask(be), exp_w);
            end
        end
        step();
        chk("bad_writes", bad_wr, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/rfs_frame_writer.md
RFS_FRAME_WRITER -- requirements
Module: rfs_frame_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 37500, number of 32-bit words in the downstream on-chip memory.
REQ-002 SHALL have parameter ADDR_W, default 16, word-address width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic is rising-edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that arms capture of one frame.
REQ-006 SHALL have port s_valid  input  1  sensor byte valid.
REQ-007 SHALL have port s_data  input  8  sensor byte.
REQ-008 SHALL have port s_sop  input  1  first byte of frame; qualified by s_valid.
REQ-009 SHALL have port s_eop  input  1  last byte of frame; qualified by s_valid.
REQ-010 SHALL have port s_ready  output  1  byte accepted when s_valid && s_ready.
REQ-011 SHALL have port m_address  output  ADDR_W  memory word address.
REQ-012 SHALL have port m_byteenable  output  4  memory byte lanes.
REQ-013 SHALL have port m_chipselect  output  1  memory select; high only with m_write.
REQ-014 SHALL have port m_write  output  1  memory write strobe; one word per cycle.
REQ-015 SHALL have port m_writedata  output  32  memory write data.
REQ-016 SHALL have port m_clken  output  1  memory clock enable; constant 1 out of reset.
REQ-017 SHALL have port busy  output  1  high in ARMED, CAPTURE, FLUSH.
REQ-018 SHALL have port frame_done  output  1  one-cycle pulse at frame end.
REQ-019 SHALL have port word_count  output  ADDR_W  words written in current/last frame.
REQ-020 SHALL have port overflow  output  1  sticky: bytes dropped because DEPTH was reached.
REQ-021 SHALL have port resync  output  1  sticky: s_sop seen mid-frame.

Function
REQ-022 SHALL implement FSM IDLE, ARMED, CAPTURE, FLUSH; start in IDLE -> ARMED, clearing word_count, overflow, resync, byte lane and address.
REQ-023 SHALL ignore start in any state other than IDLE.
REQ-024 SHALL assert s_ready in ARMED and CAPTURE; deassert in IDLE and FLUSH.
REQ-025 SHALL, in ARMED, discard accepted bytes without s_sop; an accepted s_sop byte enters CAPTURE as lane 0.
REQ-026 SHALL pack bytes little-endian: lane n (0..3) of the word at bits [8n+7:8n].
REQ-027 SHALL, when lane 3 is accepted, write the word on the next cycle: m_write=m_chipselect=1, m_byteenable=4'hF, m_address=current address; then increment address and word_count.
REQ-028 SHALL register all m_* outputs; write latency is exactly 1 cycle after the completing byte.
REQ-029 SHALL, on accepted s_eop with lanes 0..k (k<3) filled, go to FLUSH, write the partial word next cycle with m_byteenable bit n = 1 for n<=k only, then pulse frame_done and return to IDLE.
REQ-030 SHALL, on accepted s_eop at lane 3, perform the normal full write and pulse frame_done in the same cycle as that write, then go IDLE.
REQ-031 SHALL, when address == DEPTH, suppress all further writes, set overflow, keep s_ready high and consume bytes until s_eop, then pulse frame_done.
REQ-032 SHALL, on accepted s_sop in CAPTURE, discard the partial word, reset address and word_count to 0, set resync, and treat the byte as lane 0 of a new frame.
REQ-033 SHALL treat s_sop and s_eop on the same byte as a one-byte frame (m_byteenable=4'b0001).
REQ-034 SHALL never issue more than one write per cycle or write when address >= DEPTH.
REQ-035 SHALL hold word_count, overflow, resync stable in IDLE until next start.

Reset
REQ-036 SHALL, on reset_n low, asynchronously force IDLE, s_ready=0, m_write=m_chipselect=0, m_address=0, m_byteenable=0, m_writedata=0, busy=0, frame_done=0, word_count=0, overflow=0, resync=0; m_clken=1.
REQ-037 SHALL, on reset mid-frame, drop any partial word with no write issued; capture resumes only after a new start.

Verification
REQ-038 start, 8 bytes 0x01..0x08 (sop first, eop last) -> writes addr0=0x04030201 BE=F, addr1=0x08070605 BE=F, frame_done with second write, word_count=2.
REQ-039 start, 6 bytes 0xA0..0xA5 -> addr0=0x A3A2A1A0 BE=F, FLUSH write addr1 data[15:0]=0xA5A4 BE=0011, frame_done next cycle, word_count=2.
REQ-040 DEPTH=4, 20-byte frame -> exactly 4 writes, addr 0..3, overflow=1, frame_done after byte 20, word_count=4.
REQ-041 bytes before start and non-sop bytes in ARMED -> no writes; sop-sop-mid-frame after 5 bytes -> resync=1, next write at addr0 from new sop byte.
REQ-042 reset_n low after 3 bytes of frame -> no write, all outputs at reset values immediately; later start+4-byte frame writes addr0.
REQ-043 random s_valid gaps, 1000 frames of random length -> scoreboard memory image matches byte stream; no write while address >= DEPTH.
